// File: rtl/controle_cronometro_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package pacote_cronometro;

    // Controller states; encodings are visible on the estado port.
    typedef enum logic [1:0] {
        ZERADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        VOLTA    = 2'b11
    } estado_t;

    localparam int unsigned NUM_DIGITOS = 4;

endpackage

// File: rtl/controle_cronometro_gerador_pulso.sv
// Modulo-DIVISOR divider with enable and synchronous clear.
// pulso is high while enabled and sitting on the terminal count.
module gerador_pulso #(
    parameter int unsigned DIVISOR = 10
) (
    input  logic clock,
    input  logic resetN,
    input  logic habilitar,
    input  logic zerar,
    output logic pulso
);

    localparam int unsigned LARGURA = $clog2(DIVISOR);
    localparam logic [LARGURA-1:0] TERMINAL = LARGURA'(DIVISOR - 1);

    logic [LARGURA-1:0] contagem;

    // Count 0..DIVISOR-1 while enabled, hold otherwise; clear has priority.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            contagem <= '0;
        end else if (zerar) begin
            contagem <= '0;
        end else if (habilitar) begin
            if (contagem == TERMINAL) begin
                contagem <= '0;
            end else begin
                contagem <= contagem + 1'b1;
            end
        end
    end

    assign pulso = habilitar && (contagem == TERMINAL);

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch sequencing controller: button conditioning, start/pause/lap/clear
// FSM, one-second count-enable and 4-digit display scan.
// Optional feature: define DEBOUNCE_EN to insert a stability filter per button.
module controle_cronometro
    import pacote_cronometro::*;
#(
    parameter int unsigned DIVISOR_SEGUNDO   = 50_000_000,
    parameter int unsigned DIVISOR_VARREDURA = 50_000,
    parameter int unsigned FILTRO_CICLOS     = 1_000_000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       botaoIniciar,
    input  logic       botaoZerar,
    input  logic       botaoVolta,
    output logic       pulsoSegundo,
    output logic       limpar,
    output logic       congelar,
    output logic [1:0] indiceDigito,
    output logic [3:0] digitoAtivo,
    output logic [1:0] estado
);

    // Bit order for all button vectors: {volta, zerar, iniciar}.
    logic [2:0] botoes;
    logic [2:0] sinc1, sinc2;
    logic [2:0] nivel;
    logic [2:0] anterior;
    logic [2:0] eventos;

    estado_t estado_atual, estado_proximo;
    logic    gera_limpar;
    logic    contando;
    logic    zera_segundo;
    logic    passo_varredura;

    assign botoes = {botaoVolta, botaoZerar, botaoIniciar};

    // Two-flop synchronizer for the asynchronous push-buttons.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sinc1 <= '0;
            sinc2 <= '0;
        end else begin
            sinc1 <= botoes;
            sinc2 <= sinc1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned LARGURA_FILTRO = $clog2(FILTRO_CICLOS + 1);
    localparam logic [LARGURA_FILTRO-1:0] FILTRO_FIM = LARGURA_FILTRO'(FILTRO_CICLOS - 1);

    logic [2:0]                filtrado;
    logic [LARGURA_FILTRO-1:0] contagem_filtro [3];

    // Accept a new level only after it differs for FILTRO_CICLOS consecutive cycles.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            filtrado <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                contagem_filtro[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sinc2[i] != filtrado[i]) begin
                    if (contagem_filtro[i] == FILTRO_FIM) begin
                        filtrado[i]        <= sinc2[i];
                        contagem_filtro[i] <= '0;
                    end else begin
                        contagem_filtro[i] <= contagem_filtro[i] + 1'b1;
                    end
                end else begin
                    contagem_filtro[i] <= '0;
                end
            end
        end
    end

    assign nivel = filtrado;
`else
    assign nivel = sinc2;
`endif

    // Edge-detector register: one event per press, however long it is held.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            anterior <= '0;
        end else begin
            anterior <= nivel;
        end
    end

    assign eventos = nivel & ~anterior;

    // Next-state logic; zerar beats iniciar beats volta.
    always_comb begin
        estado_proximo = estado_atual;
        gera_limpar    = 1'b0;
        if (eventos[1]) begin
            estado_proximo = ZERADO;
            gera_limpar    = 1'b1;
        end else if (eventos[0]) begin
            case (estado_atual)
                CONTANDO, VOLTA: estado_proximo = PAUSADO;
                default:         estado_proximo = CONTANDO;
            endcase
        end else if (eventos[2]) begin
            case (estado_atual)
                CONTANDO: estado_proximo = VOLTA;
                VOLTA:    estado_proximo = CONTANDO;
                default:  estado_proximo = estado_atual;
            endcase
        end
    end

    // State register plus registered limpar/congelar aligned with the new state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado_atual <= ZERADO;
            limpar       <= 1'b0;
            congelar     <= 1'b0;
        end else begin
            estado_atual <= estado_proximo;
            limpar       <= gera_limpar;
            congelar     <= (estado_proximo == VOLTA);
        end
    end

    assign estado   = estado_atual;
    assign contando = (estado_atual == CONTANDO) || (estado_atual == VOLTA);
    // Clearing on the next state zeroes the prescaler on the edge that enters ZERADO.
    assign zera_segundo = (estado_proximo == ZERADO);

    gerador_pulso #(
        .DIVISOR(DIVISOR_SEGUNDO)
    ) u_prescaler_segundo (
        .clock    (clock),
        .resetN   (resetN),
        .habilitar(contando),
        .zerar    (zera_segundo),
        .pulso    (pulsoSegundo)
    );

    gerador_pulso #(
        .DIVISOR(DIVISOR_VARREDURA)
    ) u_prescaler_varredura (
        .clock    (clock),
        .resetN   (resetN),
        .habilitar(1'b1),
        .zerar    (1'b0),
        .pulso    (passo_varredura)
    );

    // Digit scan index, advanced once per scan period.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            indiceDigito <= '0;
        end else if (passo_varredura) begin
            if (indiceDigito == 2'(NUM_DIGITOS - 1)) begin
                indiceDigito <= '0;
            end else begin
                indiceDigito <= indiceDigito + 1'b1;
            end
        end
    end

    assign digitoAtivo = NUM_DIGITOS'(1) << indiceDigito;

endmodule

// File: tb/tb_controle_cronometro.sv
// Self-checking bench for controle_cronometro with a cycle-level reference model.
module tb_controle_cronometro;

    localparam int DIVS = 10;
    localparam int DIVV = 4;
    localparam int FILT = 3;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 3 + FILT;
    localparam int PLEN = 5;
`else
    localparam int LAT  = 3;
    localparam int PLEN = 1;
`endif

    logic       clock = 1'b0;
    logic       resetN;
    logic       botaoIniciar, botaoZerar, botaoVolta;
    logic       pulsoSegundo, limpar, congelar;
    logic [1:0] indiceDigito;
    logic [3:0] digitoAtivo;
    logic [1:0] estado;

    int vectors = 0;
    int miscompares = 0;

    controle_cronometro #(
        .DIVISOR_SEGUNDO  (DIVS),
        .DIVISOR_VARREDURA(DIVV),
        .FILTRO_CICLOS    (FILT)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .botaoIniciar(botaoIniciar),
        .botaoZerar  (botaoZerar),
        .botaoVolta  (botaoVolta),
        .pulsoSegundo(pulsoSegundo),
        .limpar      (limpar),
        .congelar    (congelar),
        .indiceDigito(indiceDigito),
        .digitoAtivo (digitoAtivo),
        .estado      (estado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Buttons as {volta, zerar, iniciar}. lev(n) is the level the edge detector
    // sees after edge n; the FSM at edge n acts on lev(n-1) rising vs lev(n-2).
    logic [2:0] botoes;
    assign botoes = {botaoVolta, botaoZerar, botaoIniciar};

    logic [2:0] raw_d1, raw_d2, lev_d1, lev_d2, mfilt;
    int         run [3];
    logic [1:0] m_estado;
    logic       m_limpar;
    int         m_frac;
    int         k;

    always @(posedge clock or negedge resetN) begin : modelo
        logic [2:0] ev, lev_n, filt_n;
        int         run_n [3];
        logic [1:0] nxt;
        logic       lim;
        if (!resetN) begin
            raw_d1 <= '0; raw_d2 <= '0; lev_d1 <= '0; lev_d2 <= '0; mfilt <= '0;
            for (int b = 0; b < 3; b++) run[b] <= 0;
            m_estado <= 2'd0; m_limpar <= 1'b0; m_frac <= 0; k <= 0;
        end else begin
            ev     = lev_d1 & ~lev_d2;
            filt_n = mfilt;
            for (int b = 0; b < 3; b++) begin
                run_n[b] = run[b];
                if (raw_d2[b] != mfilt[b]) begin
                    run_n[b]++;
                    if (run_n[b] == FILT) begin
                        filt_n[b] = raw_d2[b];
                        run_n[b]  = 0;
                    end
                end else begin
                    run_n[b] = 0;
                end
            end
`ifdef DEBOUNCE_EN
            lev_n = filt_n;
`else
            lev_n = raw_d1;
`endif
            nxt = m_estado;
            lim = 1'b0;
            if (ev[1]) begin
                nxt = 2'd0; lim = 1'b1;
            end else if (ev[0]) begin
                nxt = (m_estado == 2'd1 || m_estado == 2'd3) ? 2'd2 : 2'd1;
            end else if (ev[2]) begin
                if (m_estado == 2'd1) nxt = 2'd3;
                else if (m_estado == 2'd3) nxt = 2'd1;
            end
            if (nxt == 2'd0) m_frac <= 0;
            else if (m_estado == 2'd1 || m_estado == 2'd3) m_frac <= (m_frac + 1) % DIVS;
            m_estado <= nxt;
            m_limpar <= lim;
            k        <= k + 1;
            raw_d2 <= raw_d1; raw_d1 <= botoes;
            lev_d2 <= lev_d1; lev_d1 <= lev_n;
            mfilt  <= filt_n;
            for (int b = 0; b < 3; b++) run[b] <= run_n[b];
        end
    end

    logic       m_pulso;
    logic [1:0] m_idx;
    logic [3:0] m_dig;
    logic [10:0] observado, esperado;
    always_comb begin
        m_pulso  = (m_estado == 2'd1 || m_estado == 2'd3) && (m_frac == DIVS - 1);
        m_idx    = 2'((k / DIVV) % 4);
        m_dig    = 4'b0001 << m_idx;
        esperado = {m_estado, m_pulso, m_limpar, (m_estado == 2'd3), m_idx, m_dig};
    end
    assign observado = {estado, pulsoSegundo, limpar, congelar, indiceDigito, digitoAtivo};

    localparam logic [10:0] RESET_VEC = {2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0001};

    task automatic drive(input logic [2:0] b);
        {botaoVolta, botaoZerar, botaoIniciar} = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetN = 1'b0;
        drive(3'b000);
        repeat (3) @(negedge clock);
        vectors++;
        if (observado !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset: got %b expected %b", observado, RESET_VEC);
        end
        resetN = 1'b1;
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL idle cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (pulsoSegundo) pulses++;
        end
        vectors++;
        if (pulses !== 0 || estado !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_quiet: got pulses=%0d estado=%b expected 0 and 00", pulses, estado);
        end
    endtask

    task automatic test_start();
        int pulses = 0;
        @(negedge clock);
        drive(3'b001);
        for (int i = 1; i <= LAT + 49; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL start cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (i < LAT && estado !== 2'b00) begin
                miscompares++;
                $display("FAIL start_early cycle %0d: got estado %b expected 00", i, estado);
            end
            if (i == LAT) begin
                vectors++;
                if (estado !== 2'b01) begin
                    miscompares++;
                    $display("FAIL start_latency: got estado %b expected 01", estado);
                end
            end
            if (i >= LAT && pulsoSegundo) pulses++;
            if (i == PLEN) drive(3'b000);
        end
        vectors++;
        if (pulses !== 5) begin
            miscompares++;
            $display("FAIL start_pulses: got %0d expected 5", pulses);
        end
    endtask

    task automatic test_pause_resume();
        int  guard = 0;
        int  paused_pulses = 0;
        bit  seen = 0;
        while (!(m_estado == 2'd1 && m_frac == 6) && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        vectors++;
        if (guard >= 40) begin
            miscompares++;
            $display("FAIL pause_align: got no prescaler=6 within 40 cycles expected one");
        end
        drive(3'b001);
        for (int i = 1; i <= LAT + 20; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL pause cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (i > LAT && pulsoSegundo) paused_pulses++;
            if (i == 20) drive(3'b000);
        end
        vectors++;
        if (estado !== 2'b10 || paused_pulses !== 0) begin
            miscompares++;
            $display("FAIL pause_hold: got estado=%b pulses=%0d expected 10 and 0", estado, paused_pulses);
        end
        drive(3'b001);
        for (int i = 1; i <= LAT + DIVS; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL resume cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (pulsoSegundo) seen = 1;
            if (i == PLEN) drive(3'b000);
        end
        vectors++;
        if (!seen || estado !== 2'b01) begin
            miscompares++;
            $display("FAIL resume_pulse: got seen=%0d estado=%b expected 1 and 01", seen, estado);
        end
    endtask

    task automatic test_lap();
        int pulses = 0;
        drive(3'b100);
        for (int i = 1; i <= LAT + 25; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL lap cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (i > LAT && pulsoSegundo) pulses++;
            if (i == PLEN) drive(3'b000);
        end
        vectors++;
        if (estado !== 2'b11 || congelar !== 1'b1 || pulses < 2) begin
            miscompares++;
            $display("FAIL lap_on: got estado=%b congelar=%b pulses=%0d expected 11, 1, >=2", estado, congelar, pulses);
        end
        @(negedge clock);
        drive(3'b100);
        for (int i = 1; i <= LAT + 4; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL lap_off cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (i == PLEN) drive(3'b000);
        end
        vectors++;
        if (estado !== 2'b01 || congelar !== 1'b0) begin
            miscompares++;
            $display("FAIL lap_off: got estado=%b congelar=%b expected 01 and 0", estado, congelar);
        end
    endtask

    task automatic test_clear_priority();
        for (int round = 0; round < 2; round++) begin
            int clears = 0;
            drive(round == 0 ? 3'b011 : 3'b010);
            for (int i = 1; i <= LAT + 10; i++) begin
                @(negedge clock);
                vectors++;
                if (observado !== esperado) begin
                    miscompares++;
                    $display("FAIL clear%0d cycle %0d: got %b expected %b", round, i, observado, esperado);
                end
                if (limpar) begin
                    clears++;
                    if (estado !== 2'b00) begin
                        miscompares++;
                        $display("FAIL clear%0d_align: got estado %b expected 00", round, estado);
                    end
                end
                if (i == PLEN) drive(3'b000);
            end
            vectors++;
            if (clears !== 1 || estado !== 2'b00) begin
                miscompares++;
                $display("FAIL clear%0d_count: got clears=%0d estado=%b expected 1 and 00", round, clears, estado);
            end
        end
    endtask

    task automatic test_glitch();
`ifdef DEBOUNCE_EN
        logic [1:0] want = 2'b00;
`else
        logic [1:0] want = 2'b01;
`endif
        drive(3'b001);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL glitch cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if (i == 2) drive(3'b000);
        end
        vectors++;
        if (estado !== want) begin
            miscompares++;
            $display("FAIL glitch_state: got %b expected %b", estado, want);
        end
    endtask

    task automatic test_random();
        logic [2:0] b = 3'b000;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b expected %b", i, observado, esperado);
            end
            if ($urandom_range(5, 0) == 0) begin
                b[$urandom_range(2, 0)] ^= 1'b1;
                drive(b);
            end
        end
        drive(3'b000);
    endtask

    task automatic test_async_reset();
        @(posedge clock);
        #2 resetN = 1'b0;
        #1;
        vectors++;
        if (observado !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", observado, RESET_VEC);
        end
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            vectors++;
            if (observado !== esperado) begin
                miscompares++;
                $display("FAIL post_reset cycle %0d: got %b expected %b", i, observado, esperado);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_start();
        test_pause_resume();
        test_lap();
        test_clear_priority();
        test_glitch();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
